// File: rtl/bram_stream_reader.sv
// bram_stream_reader: issues sequential word reads on a BRAM port with one-cycle registered
// read data and presents the returned words as a valid/ready stream. Reads are only issued
// while the output FIFO has room for every word already requested, so backpressure can
// never overflow the FIFO even though data arrives one cycle after the request.
module bram_stream_reader #(
   parameter int unsigned LEN_W      = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic [31:0]      bram_addr,
   output logic             bram_en,
   output logic [3:0]       bram_wen,
   output logic [31:0]      bram_din,
   input  logic [31:0]      bram_dout,
   output logic [31:0]      m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   // Wide enough for fifo count plus the one in-flight read.
   localparam int unsigned CNT_W = PTR_W + 2;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e             state_q, state_d;
   logic [31:0]        base_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   issued_q;
   logic [LEN_W-1:0]   accepted_q;
   logic [LEN_W-1:0]   len_m1;
   logic               inflight_q;

   logic [31:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]     count_q;

   logic [CNT_W-1:0]   credit_used;
   logic               accept_cmd;
   logic               issue;
   logic               last_issue;
   logic               push;
   logic               pop;

   // Issue/credit decode and handshake qualifiers.
   always_comb begin
      accept_cmd  = (state_q == StIdle) && start;
      len_m1      = len_q - LEN_W'(1);
      credit_used = CNT_W'(count_q) + CNT_W'(inflight_q);
      issue       = (state_q == StRead) && (issued_q < len_q) && (credit_used < DEPTH_C);
      last_issue  = issue && (issued_q == len_m1);
      push        = inflight_q;
      pop         = m_valid && m_ready;
   end

   // Output decode: BRAM request side, status and stream side.
   always_comb begin
      bram_en   = issue;
      bram_addr = issue ? (base_q + (32'(issued_q) << 2)) : 32'h0;
      bram_wen  = 4'b0000;
      bram_din  = 32'h0;
      busy      = (state_q == StRead) || (state_q == StDrain);
      done      = (state_q == StDone);
      m_valid   = (count_q != '0);
      // Gated so the stream reads zero while empty, including straight after reset.
      m_data    = m_valid ? fifo_mem[rd_ptr_q] : 32'h0;
      m_last    = m_valid && (accepted_q == len_m1);
   end

   // Next-state logic; DRAIN finishes on the handshake of the final word.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = (len == '0) ? StDone : StRead;
         end
         StRead: begin
            if (last_issue) state_d = StDrain;
         end
         StDrain: begin
            if ((accepted_q == len_q) || (pop && (accepted_q == len_m1))) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State, command latch and transfer counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         base_q     <= 32'h0;
         len_q      <= '0;
         issued_q   <= '0;
         accepted_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         if (accept_cmd) begin
            base_q     <= base_addr & 32'hFFFF_FFFC;
            len_q      <= len;
            issued_q   <= '0;
            accepted_q <= '0;
         end else begin
            if (issue) issued_q <= issued_q + LEN_W'(1);
            if (pop)   accepted_q <= accepted_q + LEN_W'(1);
         end
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_q <= count_q + (PTR_W + 1)'(1);
         else if (!push && pop) count_q <= count_q - (PTR_W + 1)'(1);
      end
   end

   // FIFO storage captures the BRAM word returned for the previous cycle's request.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= bram_dout;
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: a behavioural BRAM with one-cycle read data,
// per-scenario tasks, and expected streams computed directly from base/len.
module tb_bram_stream_reader;

   localparam int unsigned LEN_W = 16;
   localparam int unsigned DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [31:0]      base_addr;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             done;
   logic [31:0]      bram_addr;
   logic             bram_en;
   logic [3:0]       bram_wen;
   logic [31:0]      bram_din;
   logic [31:0]      bram_dout;
   logic [31:0]      m_data;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;

   int checks = 0;
   int errors = 0;
   logic [31:0] salt = 32'h0;

   // Observations gathered by run().
   logic [31:0] addr_q[$];
   logic [31:0] data_q[$];
   logic        last_q[$];
   int          en_cyc_q[$];
   int done_cnt, done_cyc, last_hs_cyc, first_valid_cyc, hold_en;
   int side_bad, hold_bad, busy_bad, cyc;
   logic [31:0] held_word;
   bit timed_out;

   bram_stream_reader #(.LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en),
      .bram_wen(bram_wen), .bram_din(bram_din), .bram_dout(bram_dout),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   // Behavioural BRAM: data for the request appears the cycle after bram_en.
   always @(posedge clk) if (bram_en) bram_dout <= word_of(bram_addr);

   function automatic logic [31:0] get_a(input int i);
      if (i < addr_q.size()) return addr_q[i];
      return 32'hxxxx_xxxx;
   endfunction
   function automatic logic [31:0] get_d(input int i);
      if (i < data_q.size()) return data_q[i];
      return 32'hxxxx_xxxx;
   endfunction
   function automatic logic get_l(input int i);
      if (i < last_q.size()) return last_q[i];
      return 1'bx;
   endfunction
   function automatic int get_e(input int i);
      if (i < en_cyc_q.size()) return en_cyc_q[i];
      return -1;
   endfunction

   // Runs one transfer. mode: 0 ready=1, 1 alternating, 2 ready=0 for 'hold' cycles, 3 random.
   // poke issues a second start with different base/len mid-transfer.
   task automatic run(input logic [31:0] b, input int n, input int mode, input int hold,
                      input bit poke);
      logic [31:0] pd;
      logic pv, pr, pl;
      addr_q.delete(); data_q.delete(); last_q.delete(); en_cyc_q.delete();
      done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; first_valid_cyc = -1; hold_en = 0;
      side_bad = 0; hold_bad = 0; busy_bad = 0; timed_out = 0; held_word = 32'h0;
      pv = 0; pr = 0; pl = 0; pd = 32'h0;
      @(negedge clk);
      base_addr = b; len = LEN_W'(n); start = 1'b1; m_ready = 1'b0;
      cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         start = poke && (cyc == 3);
         if (start) begin
            base_addr = ~b;
            len = LEN_W'(n + 5);
         end
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = cyc[0];
            2:       m_ready = (cyc > hold);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         if (bram_en) begin
            addr_q.push_back(bram_addr);
            en_cyc_q.push_back(cyc);
            if (cyc <= hold) hold_en++;
         end
         if (cyc == hold) held_word = m_data;
         if (bram_wen !== 4'b0000 || bram_din !== 32'h0) side_bad++;
         if (m_last && !m_valid) side_bad++;
         if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) hold_bad++;
         if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (m_valid && m_ready) begin
            data_q.push_back(m_data);
            last_q.push_back(m_last);
            if (m_last) last_hs_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) busy_bad++;
         end else if (done_cnt == 0 && !busy) begin
            busy_bad++;
         end
         pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
         if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
         if (cyc >= 400) begin
            timed_out = 1;
            break;
         end
      end
      m_ready = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = 32'h0; len = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, bram_en, m_valid, m_last} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 00000", {busy, done, bram_en, m_valid, m_last});
      end
      checks++;
      if (bram_addr !== 32'h0 || m_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_buses addr %h data %h want 0", bram_addr, m_data);
      end
      checks++;
      if (bram_wen !== 4'b0 || bram_din !== 32'h0) begin
         errors++;
         $display("FAIL reset_wen wen %h din %h want 0", bram_wen, bram_din);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [31:0] b;
      b = 32'h100;
      salt = $urandom;
      run(b, 4, 0, 0, 1'b0);
      checks++;
      if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (get_a(i) !== b + 32'(4 * i) || get_e(i) != i + 1) begin
            errors++;
            $display("FAIL basic_addr[%0d] got %h@%0d want %h@%0d", i, get_a(i), get_e(i),
                     b + 32'(4 * i), i + 1);
         end
         checks++;
         if (get_d(i) !== word_of(b + 32'(4 * i)) || get_l(i) !== (i == 3)) begin
            errors++;
            $display("FAIL basic_data[%0d] got %h/%b want %h/%b", i, get_d(i), get_l(i),
                     word_of(b + 32'(4 * i)), (i == 3));
         end
      end
      checks++;
      if (addr_q.size() != 4 || data_q.size() != 4) begin
         errors++;
         $display("FAIL basic_count got %0d/%0d want 4/4", addr_q.size(), data_q.size());
      end
      checks++;
      if (first_valid_cyc != 3) begin
         errors++;
         $display("FAIL basic_latency got %0d want 3", first_valid_cyc);
      end
      checks++;
      if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
         errors++;
         $display("FAIL basic_done got cnt %0d cyc %0d want 1 cyc %0d", done_cnt, done_cyc,
                  last_hs_cyc + 1);
      end
      checks++;
      if (side_bad != 0 || busy_bad != 0 || hold_bad != 0) begin
         errors++;
         $display("FAIL basic_side got %0d/%0d/%0d want 0", side_bad, busy_bad, hold_bad);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] b;
      b = $urandom & 32'hFFFF_FFFC;
      salt = $urandom;
      run(b, 10, 2, 20, 1'b0);
      checks++;
      if (hold_en != int'(DEPTH)) begin
         errors++;
         $display("FAIL bp_issued got %0d want %0d", hold_en, DEPTH);
      end
      checks++;
      if (held_word !== word_of(b)) begin
         errors++;
         $display("FAIL bp_held got %h want %h", held_word, word_of(b));
      end
      checks++;
      if (data_q.size() != 10 || hold_bad != 0) begin
         errors++;
         $display("FAIL bp_count got %0d hold_bad %0d want 10 0", data_q.size(), hold_bad);
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (get_d(i) !== word_of(b + 32'(4 * i)) || get_l(i) !== (i == 9)) begin
            errors++;
            $display("FAIL bp_data[%0d] got %h/%b want %h/%b", i, get_d(i), get_l(i),
                     word_of(b + 32'(4 * i)), (i == 9));
         end
      end
      checks++;
      if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
         errors++;
         $display("FAIL bp_done got cnt %0d cyc %0d want 1 cyc %0d", done_cnt, done_cyc,
                  last_hs_cyc + 1);
      end
   endtask

   task automatic test_toggle_ready();
      logic [31:0] b;
      b = $urandom & 32'h0FFF_FFFC;
      salt = $urandom;
      run(b, 7, 1, 0, 1'b0);
      checks++;
      if (data_q.size() != 7 || hold_bad != 0) begin
         errors++;
         $display("FAIL toggle_count got %0d hold_bad %0d want 7 0", data_q.size(), hold_bad);
      end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (get_d(i) !== word_of(b + 32'(4 * i)) || get_l(i) !== (i == 6)) begin
            errors++;
            $display("FAIL toggle_data[%0d] got %h/%b want %h/%b", i, get_d(i), get_l(i),
                     word_of(b + 32'(4 * i)), (i == 6));
         end
      end
      checks++;
      if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
         errors++;
         $display("FAIL toggle_done got cnt %0d cyc %0d want 1 cyc %0d", done_cnt, done_cyc,
                  last_hs_cyc + 1);
      end
   endtask

   task automatic test_zero_len_ignored_start();
      logic [31:0] b;
      b = $urandom;
      salt = $urandom;
      run(b, 0, 0, 0, 1'b0);
      checks++;
      if (addr_q.size() != 0 || first_valid_cyc != -1) begin
         errors++;
         $display("FAIL zero_activity got en %0d valid@%0d want 0 -1", addr_q.size(),
                  first_valid_cyc);
      end
      checks++;
      if (done_cnt != 1 || done_cyc < 1 || done_cyc > 2) begin
         errors++;
         $display("FAIL zero_done got cnt %0d cyc %0d want 1 cyc 1..2", done_cnt, done_cyc);
      end
      b = $urandom & 32'h7FFF_FFF0;
      run(b, 6, 0, 0, 1'b1);
      checks++;
      if (addr_q.size() != 6 || data_q.size() != 6) begin
         errors++;
         $display("FAIL ignore_count got %0d/%0d want 6/6", addr_q.size(), data_q.size());
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (get_a(i) !== b + 32'(4 * i) || get_d(i) !== word_of(b + 32'(4 * i))) begin
            errors++;
            $display("FAIL ignore_word[%0d] got %h/%h want %h/%h", i, get_a(i), get_d(i),
                     b + 32'(4 * i), word_of(b + 32'(4 * i)));
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_a [4];
      exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      salt = $urandom;
      run(32'hFFFF_FFFA, 4, 0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (get_a(i) !== exp_a[i] || get_d(i) !== word_of(exp_a[i])) begin
            errors++;
            $display("FAIL wrap[%0d] got %h/%h want %h/%h", i, get_a(i), get_d(i), exp_a[i],
                     word_of(exp_a[i]));
         end
      end
      checks++;
      if (done_cnt != 1 || addr_q.size() != 4) begin
         errors++;
         $display("FAIL wrap_done got cnt %0d en %0d want 1 4", done_cnt, addr_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] b;
      int n, k;
      logic was_en;
      b = $urandom & 32'hFFFF_FFFC;
      salt = $urandom;
      @(negedge clk);
      base_addr = b; len = LEN_W'(8); start = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (m_valid) n = 1; else n = 0;
      k = 0;
      while (n < 3 && k < 50) begin
         @(negedge clk);
         k++;
         if (m_valid) n++;
      end
      checks++;
      if (n != 3) begin errors++; $display("FAIL rstmid_reach got %0d want 3", n); end
      @(posedge clk);
      #1;
      was_en = bram_en;
      rst = 1'b1;
      #1;
      checks++;
      if (was_en !== 1'b1) begin errors++; $display("FAIL rstmid_inflight got %b want 1", was_en); end
      checks++;
      if ({busy, done, bram_en, m_valid, m_last} !== 5'b0 || bram_addr !== 32'h0 ||
          m_data !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_outputs got %b %h %h want 0", {busy, done, bram_en, m_valid, m_last},
                  bram_addr, m_data);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_empty got valid %b busy %b want 0 0", m_valid, busy);
      end
      b = $urandom & 32'hFFFF_FFFC;
      salt = $urandom;
      run(b, 2, 0, 0, 1'b0);
      checks++;
      if (data_q.size() != 2 || done_cnt != 1) begin
         errors++;
         $display("FAIL rstmid_new_count got %0d done %0d want 2 1", data_q.size(), done_cnt);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (get_d(i) !== word_of(b + 32'(4 * i)) || get_l(i) !== (i == 1)) begin
            errors++;
            $display("FAIL rstmid_new[%0d] got %h/%b want %h/%b", i, get_d(i), get_l(i),
                     word_of(b + 32'(4 * i)), (i == 1));
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] b, ab;
      int n;
      for (int t = 0; t < 6; t++) begin
         b = $urandom;
         ab = b & 32'hFFFF_FFFC;
         n = $urandom_range(1, 20);
         salt = $urandom;
         run(b, n, 3, 0, 1'b0);
         checks++;
         if (timed_out || data_q.size() != n || addr_q.size() != n) begin
            errors++;
            $display("FAIL rand%0d_count got %0d/%0d to %0b want %0d", t, data_q.size(),
                     addr_q.size(), timed_out, n);
         end
         for (int i = 0; i < n; i++) begin
            checks++;
            if (get_a(i) !== ab + 32'(4 * i) || get_d(i) !== word_of(ab + 32'(4 * i)) ||
                get_l(i) !== (i == n - 1)) begin
               errors++;
               $display("FAIL rand%0d_word[%0d] got %h/%h/%b want %h/%h/%b", t, i, get_a(i),
                        get_d(i), get_l(i), ab + 32'(4 * i), word_of(ab + 32'(4 * i)),
                        (i == n - 1));
            end
         end
         checks++;
         if (done_cnt != 1 || done_cyc != last_hs_cyc + 1 || hold_bad != 0 || busy_bad != 0 ||
             side_bad != 0) begin
            errors++;
            $display("FAIL rand%0d_ctrl got done %0d@%0d hs@%0d hold %0d busy %0d side %0d", t,
                     done_cnt, done_cyc, last_hs_cyc, hold_bad, busy_bad, side_bad);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_toggle_ready();
      test_zero_len_ignored_start();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
